// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports (A = CPU, B = DMA) and the shared
//   memory port of dmem_arbiter.
//   Requester side: x_req/x_we/x_addr/x_wdata/x_be in, x_ack/x_rdata out.
//   Memory side: daddr/dwdata/dwe out, drdata in (combinational from daddr).
//   Handshake: a requester raises x_req with its command fields stable and
//   keeps them until x_ack pulses for one cycle; x_rdata of a read is valid
//   while x_ack is high and is held until the next read on that port.
//   modport slave  : arbiter view.
//   modport master : requester + memory-model view (testbench).
interface dmem_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_be;
    logic        a_ack;
    logic [31:0] a_rdata;

    logic        b_req;
    logic        b_we;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_be;
    logic        b_ack;
    logic [31:0] b_rdata;

    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, a_be,
        input  b_req, b_we, b_addr, b_wdata, b_be,
        input  drdata,
        output a_ack, a_rdata, b_ack, b_rdata,
        output daddr, dwdata, dwe
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata, a_be,
        output b_req, b_we, b_addr, b_wdata, b_be,
        output drdata,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  daddr, dwdata, dwe
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port round-robin arbiter in front of a single-ported data memory.
//   One transaction at a time: IDLE grants, WR (one cycle) or RD (RD_WAIT
//   cycles) drives memory, ACK pulses the winner's ack.
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        dmem_arbiter_if.slave (requesters + memory port)
//     dbg_state  current FSM state (0 IDLE, 1 WR, 2 RD, 3 ACK)
//   Parameter RD_WAIT (1..15): cycles daddr is held before drdata is
//   captured.
module dmem_arbiter #(
    parameter int unsigned RD_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_arbiter_if.slave        bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        ACK  = 2'd3
    } state_t;

    localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);

    state_t      state;
    state_t      state_nxt;

    // last_b doubles as the "current grant" during WR/RD/ACK and as the
    // round-robin pointer once back in IDLE. Reset value B lets A win the
    // first tie.
    logic        last_b;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [3:0]  cnt;
    logic [31:0] a_rdata_q;
    logic [31:0] b_rdata_q;

    logic        any_req;
    logic        win_b;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;
    logic        rd_done;

    always_comb begin
        any_req   = bus.a_req | bus.b_req;
        win_b     = (bus.a_req && bus.b_req) ? ~last_b : bus.b_req;
        sel_we    = win_b ? bus.b_we    : bus.a_we;
        sel_addr  = win_b ? bus.b_addr  : bus.a_addr;
        sel_wdata = win_b ? bus.b_wdata : bus.a_wdata;
        sel_be    = win_b ? bus.b_be    : bus.a_be;
        rd_done   = (cnt == RD_LAST);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req) state_nxt = sel_we ? WR : RD;
            WR:   state_nxt = ACK;
            RD:   if (rd_done) state_nxt = ACK;
            ACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b    <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            cnt       <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                last_b  <= win_b;
                addr_q  <= {sel_addr[31:2], 2'b00};
                wdata_q <= sel_wdata;
                be_q    <= sel_be;
                cnt     <= '0;
            end
            if (state == RD) begin
                if (rd_done) begin
                    if (last_b) b_rdata_q <= bus.drdata;
                    else        a_rdata_q <= bus.drdata;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

    // dwe is decoded from state so an asynchronous reset in WR removes the
    // write strobe immediately, without waiting for a clock edge.
    assign bus.dwe     = (state == WR) ? be_q : 4'b0000;
    assign bus.daddr   = addr_q;
    assign bus.dwdata  = wdata_q;
    assign bus.a_ack   = (state == ACK) && !last_b;
    assign bus.b_ack   = (state == ACK) &&  last_b;
    assign bus.a_rdata = a_rdata_q;
    assign bus.b_rdata = b_rdata_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Bench for dmem_arbiter with RD_WAIT = 3. Contains a word memory model
//   driven by the DUT's memory port, a reference memory updated at issue
//   time, and an ack scoreboard {port, is_read, rdata}.
module tb_dmem_arbiter;

    localparam int unsigned RD_WAIT = 3;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.RD_WAIT(RD_WAIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    assign bus.drdata = mem[bus.daddr[9:2]];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bus.dwe[i]) mem[bus.daddr[9:2]][8*i +: 8] <= bus.dwdata[8*i +: 8];
    end

    // ---------------- scoreboard ----------------
    logic [33:0] exp_q[$];
    int n_vec;
    int n_err;
    logic prev_a_ack;
    logic prev_b_ack;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        logic [33:0] e;
        if (bus.a_ack || bus.b_ack) begin
            check("ack_overlap", {63'd0, bus.a_ack & bus.b_ack}, 64'd0);
            check("ack_pulse", {63'd0, (bus.a_ack & prev_a_ack) | (bus.b_ack & prev_b_ack)}, 64'd0);
            if (exp_q.size() == 0) begin
                check("spurious_ack", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("ack_port", {63'd0, bus.b_ack}, {63'd0, e[33]});
                if (e[32])
                    check("rdata", {32'd0, bus.b_ack ? bus.b_rdata : bus.a_rdata}, {32'd0, e[31:0]});
            end
        end
        prev_a_ack <= bus.a_ack;
        prev_b_ack <= bus.b_ack;
    end

    // ---------------- driver tasks ----------------
    // Record the expectation for a transaction and update the reference memory.
    task automatic expect_txn(input bit port, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
        if (we) begin
            ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], wdata, be);
            exp_q.push_back({port, 1'b0, 32'h0});
        end else begin
            exp_q.push_back({port, 1'b1, ref_mem[addr[9:2]]});
        end
    endtask

    task automatic drive_port(input bit port, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
        if (port) begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata; bus.b_be = be;
        end else begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata; bus.a_be = be;
        end
    endtask

    // Called at the negedge on which req was raised with the DUT idle.
    task automatic wait_ack(input bit port, input bit we, input logic [31:0] addr,
                            input logic [3:0] be, input bit alt);
        int cyc;
        int wr_cyc;
        bit got;
        cyc = 0; wr_cyc = 0; got = 1'b0;
        while (!got && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (bus.dwe != 4'b0000) begin
                wr_cyc++;
                check("dwe_lanes", {60'd0, bus.dwe}, {60'd0, be});
                check("dwe_addr", {32'd0, bus.daddr}, {32'd0, addr[31:2], 2'b00});
            end
            got = port ? bus.b_ack : bus.a_ack;
            if (alt && cyc == 1) begin
                if (port) bus.b_addr = 32'h40;
                else      bus.a_addr = 32'h40;
            end
            if (alt && cyc >= 2)
                check("daddr_hold", {32'd0, bus.daddr}, {32'd0, addr[31:2], 2'b00});
        end
        check("ack_seen", {63'd0, got}, 64'd1);
        check("latency", 64'(cyc), we ? 64'd2 : 64'(RD_WAIT + 1));
        check("wr_cycles", 64'(wr_cyc), (we && be != 4'b0000) ? 64'd1 : 64'd0);
        if (port) bus.b_req = 1'b0;
        else      bus.a_req = 1'b0;
    endtask

    task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input bit alt);
        @(negedge clk);
        expect_txn(port, we, addr, wdata, be);
        drive_port(port, we, addr, wdata, be);
        wait_ack(port, we, addr, be, alt);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int acks;
        n_vec = 0;
        n_err = 0;
        prev_a_ack = 1'b0;
        prev_b_ack = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hA5000000 ^ (i * 32'h00010203);
            ref_mem[i] = 32'hA5000000 ^ (i * 32'h00010203);
        end
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0; bus.a_be = 0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0; bus.b_be = 0;
        rst_n = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state",  {62'd0, dbg_state}, 64'd0);
        check("rst_dwe",    {60'd0, bus.dwe}, 64'd0);
        check("rst_acks",   {62'd0, bus.a_ack, bus.b_ack}, 64'd0);
        check("rst_daddr",  {32'd0, bus.daddr}, 64'd0);
        check("rst_dwdata", {32'd0, bus.dwdata}, 64'd0);
        check("rst_a_rdata", {32'd0, bus.a_rdata}, 64'd0);
        check("rst_b_rdata", {32'd0, bus.b_rdata}, 64'd0);
        rst_n = 1'b1;

        // A write then readback; B read with RD_WAIT cycles
        do_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0);
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0);
        do_txn(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0);

        // partial write, then a write with no lanes enabled
        do_txn(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0100, 1'b0);
        do_txn(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0);
        do_txn(1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 4'b0000, 1'b0);
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0);

        // address changed by the requester mid-read; low address bits ignored
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b1);
        do_txn(1'b1, 1'b0, 32'h13, 32'h0, 4'b0000, 1'b1);

        // dual requests from reset: A,B,A,B
        reset_pulse();
        @(negedge clk);
        expect_txn(1'b0, 1'b1, 32'h80, 32'h0A0A0A0A, 4'b1111);
        expect_txn(1'b1, 1'b1, 32'h84, 32'h0B0B0B0B, 4'b1111);
        expect_txn(1'b0, 1'b1, 32'h80, 32'h0A0A0A0A, 4'b1111);
        expect_txn(1'b1, 1'b1, 32'h84, 32'h0B0B0B0B, 4'b1111);
        drive_port(1'b0, 1'b1, 32'h80, 32'h0A0A0A0A, 4'b1111);
        drive_port(1'b1, 1'b1, 32'h84, 32'h0B0B0B0B, 4'b1111);
        acks = 0;
        for (int c = 0; c < 60 && acks < 4; c++) begin
            @(negedge clk);
            if (bus.a_ack || bus.b_ack) acks++;
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        check("dual_acks", 64'(acks), 64'd4);
        repeat (4) @(negedge clk);
        check("dual_drain", 64'(exp_q.size()), 64'd0);

        // reset asserted while in WR
        @(negedge clk);
        drive_port(1'b0, 1'b1, 32'h20, 32'h5A5A5A5A, 4'b1111);
        @(negedge clk);
        check("pre_rst_dwe", {60'd0, bus.dwe}, 64'hF);
        #1 rst_n = 1'b0;
        #1;
        check("rst_wr_dwe", {60'd0, bus.dwe}, 64'd0);
        check("rst_wr_ack", {62'd0, bus.a_ack, bus.b_ack}, 64'd0);
        @(negedge clk);
        check("rst_wr_nowrite", {32'd0, mem[8]}, {32'd0, ref_mem[8]});
        check("rst_wr_ack2", {62'd0, bus.a_ack, bus.b_ack}, 64'd0);
        rst_n = 1'b1;
        expect_txn(1'b0, 1'b1, 32'h20, 32'h5A5A5A5A, 4'b1111);
        wait_ack(1'b0, 1'b1, 32'h20, 4'b1111, 1'b0);
        do_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'b0000, 1'b0);

        // random traffic
        for (int k = 0; k < 16; k++) begin
            logic [31:0] ra;
            ra = 32'h100 + (32'($urandom_range(0, 7)) << 2);
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
                   $urandom, 4'($urandom_range(0, 15)), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
